// File: rtl/lcd_bus_monitor_if.sv
// lcd_bus_monitor_if
//   Groups the HD44780-style character-LCD write bus.
//   master : the LCD controller that drives the bus.
//   slave  : the bus monitor that observes it.
// Signals
//   LCD_E    : enable strobe; a transfer is taken on its falling edge.
//   LCD_RS   : 0 = instruction, 1 = data.
//   LCD_RW   : 0 = write, 1 = read.
//   LCD_DATA : 8-bit bus data.
// Handshake: there is no ready/back-pressure path. A transfer is defined by
// RS/RW/DATA being stable while E is high; the transfer happens when E falls.
interface lcd_bus_monitor_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (output LCD_E, output LCD_RS, output LCD_RW, output LCD_DATA);
  modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW, input  LCD_DATA);
endinterface

// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor
//   Receiving end of an HD44780-style LCD write bus. Each falling edge of E
//   is decoded as an instruction or a data write, and a shadow 2x16 character
//   buffer plus cursor/display state is maintained for readback.
// Optional feature: define LCDMON_BUSY_EN to emulate the LCD busy time and
//   flag strobes that arrive while the emulated LCD is still busy (ERR).
// Ports
//   CLK, RESETN : clock; asynchronous active-high reset.
//   bus         : LCD bus (slave modport of lcd_bus_monitor_if).
//   RD_ADDR     : shadow-buffer index, 0-15 line 1, 16-31 line 2.
//   RD_DATA     : registered character at RD_ADDR (1 CLK latency).
//   CUR_ADDR    : DDRAM address counter.
//   DISP_ON     : display-on bit.   ENTRY_INC : entry-mode I/D bit.
//   CMD_VALID   : one-cycle pulse per accepted write strobe.
//   CMD_RS      : RS of last accepted strobe.  CMD_BYTE : its data.
//   LINE2_DONE  : one-cycle pulse when a data write lands at DDRAM 0x4F.
//   ERR         : sticky busy-violation flag (0 without LCDMON_BUSY_EN).
module lcd_bus_monitor #(
  parameter int CLEAR_BUSY  = 64,
  parameter int BUSY_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RESETN,
  lcd_bus_monitor_if.slave    bus,
  input  logic [4:0]          RD_ADDR,
  output logic [7:0]          RD_DATA,
  output logic [6:0]          CUR_ADDR,
  output logic                DISP_ON,
  output logic                ENTRY_INC,
  output logic                CMD_VALID,
  output logic                CMD_RS,
  output logic [7:0]          CMD_BYTE,
  output logic                LINE2_DONE,
  output logic                ERR
);

  // Synchronizers. Stage 3 of RS/RW/DATA lines up with e_d_q, so it holds
  // the last sample taken while E was still high.
  logic       e_s1_q, e_s2_q, e_d_q;
  logic       rs_s1_q, rs_s2_q, rs_s3_q;
  logic       rw_s1_q, rw_s2_q, rw_s3_q;
  logic [7:0] dat_s1_q, dat_s2_q, dat_s3_q;

  // Architectural state
  logic [7:0] buf_q [32];
  logic [7:0] buf_d [32];
  logic [6:0] cur_q, cur_d;
  logic       disp_q, disp_d;
  logic       inc_q, inc_d;
  logic [7:0] rd_q, rd_d;
  logic       cv_q, cv_d;
  logic       cmd_rs_q, cmd_rs_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic       l2_q, l2_d;

  logic fall, accept;

  assign fall   = ~e_s2_q & e_d_q;
  assign accept = fall & ~rw_s3_q;

  // One address-counter step. Offsets above 39 (0x28-0x3F on either line)
  // are treated as the line end before stepping.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [5:0] off;
    off = (a[5:0] > 6'd39) ? 6'd39 : a[5:0];
    if (up) step_addr = (off == 6'd39) ? {~a[6], 6'd0}  : {a[6], off + 6'd1};
    else    step_addr = (off == 6'd0)  ? {~a[6], 6'd39} : {a[6], off - 6'd1};
  endfunction

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      e_s1_q   <= 1'b0; e_s2_q   <= 1'b0; e_d_q   <= 1'b0;
      rs_s1_q  <= 1'b0; rs_s2_q  <= 1'b0; rs_s3_q <= 1'b0;
      rw_s1_q  <= 1'b0; rw_s2_q  <= 1'b0; rw_s3_q <= 1'b0;
      dat_s1_q <= 8'h00; dat_s2_q <= 8'h00; dat_s3_q <= 8'h00;
    end else begin
      e_s1_q   <= bus.LCD_E;    e_s2_q   <= e_s1_q;   e_d_q   <= e_s2_q;
      rs_s1_q  <= bus.LCD_RS;   rs_s2_q  <= rs_s1_q;  rs_s3_q <= rs_s2_q;
      rw_s1_q  <= bus.LCD_RW;   rw_s2_q  <= rw_s1_q;  rw_s3_q <= rw_s2_q;
      dat_s1_q <= bus.LCD_DATA; dat_s2_q <= dat_s1_q; dat_s3_q <= dat_s2_q;
    end
  end

  always_comb begin
    buf_d      = buf_q;
    cur_d      = cur_q;
    disp_d     = disp_q;
    inc_d      = inc_q;
    cv_d       = accept;
    cmd_rs_d   = cmd_rs_q;
    cmd_byte_d = cmd_byte_q;
    l2_d       = 1'b0;
    // Reading buf_q gives read-before-write on a same-edge write.
    rd_d       = buf_q[RD_ADDR];

    if (accept) begin
      cmd_rs_d   = rs_s3_q;
      cmd_byte_d = dat_s3_q;
      if (rs_s3_q) begin
        if (cur_q[6:4] == 3'b000) buf_d[{1'b0, cur_q[3:0]}] = dat_s3_q;
        if (cur_q[6:4] == 3'b100) buf_d[{1'b1, cur_q[3:0]}] = dat_s3_q;
        l2_d  = (cur_q == 7'h4F);
        cur_d = step_addr(cur_q, inc_q);
      end else begin
        // Highest set bit selects the instruction.
        if (dat_s3_q[7]) begin
          cur_d = dat_s3_q[6:0];
        end else if (dat_s3_q[6:4] != 3'b000) begin
          // CGRAM address, Function Set, Shift: no shadow state.
        end else if (dat_s3_q[3]) begin
          disp_d = dat_s3_q[2];
        end else if (dat_s3_q[2]) begin
          inc_d = dat_s3_q[1];
        end else if (dat_s3_q[1]) begin
          cur_d = 7'h00;
        end else if (dat_s3_q[0]) begin
          for (int i = 0; i < 32; i++) buf_d[i] = 8'h20;
          cur_d = 7'h00;
          inc_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
      cur_q      <= 7'h00;
      disp_q     <= 1'b0;
      inc_q      <= 1'b1;
      rd_q       <= 8'h20;
      cv_q       <= 1'b0;
      cmd_rs_q   <= 1'b0;
      cmd_byte_q <= 8'h00;
      l2_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) buf_q[i] <= buf_d[i];
      cur_q      <= cur_d;
      disp_q     <= disp_d;
      inc_q      <= inc_d;
      rd_q       <= rd_d;
      cv_q       <= cv_d;
      cmd_rs_q   <= cmd_rs_d;
      cmd_byte_q <= cmd_byte_d;
      l2_q       <= l2_d;
    end
  end

  assign RD_DATA    = rd_q;
  assign CUR_ADDR   = cur_q;
  assign DISP_ON    = disp_q;
  assign ENTRY_INC  = inc_q;
  assign CMD_VALID  = cv_q;
  assign CMD_RS     = cmd_rs_q;
  assign CMD_BYTE   = cmd_byte_q;
  assign LINE2_DONE = l2_q;

`ifdef LCDMON_BUSY_EN
  localparam int BMAX = (CLEAR_BUSY > BUSY_CYCLES) ? CLEAR_BUSY : BUSY_CYCLES;
  localparam int BW   = $clog2(BMAX + 1);

  logic [BW-1:0] busy_q, busy_d;
  logic          err_q, err_d;
  logic          long_cmd;

  // Clear Display and Return Home are the slow instructions.
  assign long_cmd = ~rs_s3_q & (dat_s3_q[7:2] == 6'd0) & (dat_s3_q[1:0] != 2'd0);

  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (accept) begin
      if (busy_q != '0) err_d = 1'b1;
      busy_d = long_cmd ? BW'(CLEAR_BUSY) : BW'(BUSY_CYCLES);
    end else if (busy_q != '0) begin
      busy_d = busy_q - BW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign ERR = err_q;
`else
  logic unused_params;
  assign unused_params = ^{32'(CLEAR_BUSY), 32'(BUSY_CYCLES)};
  assign ERR = 1'b0;
`endif

endmodule
